// File: rtl/ctrl_pipe_hazard.sv
// Control-signal pipeline behind the decode CMUX stage. It carries control, dest and valid
// through NUM_STAGES registers, detects load-use hazards and counts inserted bubbles.
module ctrl_pipe_hazard #(
  parameter int unsigned SIG_W      = 24,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned LOAD_BIT   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [SIG_W-1:0]            id_ctrl_i,
  input  logic                        id_valid_i,
  input  logic [REG_W-1:0]            id_dest_i,
  input  logic [REG_W-1:0]            id_rs_i,
  input  logic [REG_W-1:0]            id_rt_i,
  input  logic                        id_uses_rs_i,
  input  logic                        id_uses_rt_i,
  input  logic                        ext_stall_i,
  input  logic                        flush_i,
  output logic                        cmux_o,
  output logic                        hazard_stall_o,
  output logic [NUM_STAGES*SIG_W-1:0] stage_ctrl_o,
  output logic [NUM_STAGES*REG_W-1:0] stage_dest_o,
  output logic [NUM_STAGES-1:0]       stage_valid_o,
  output logic [CNT_W-1:0]            bubble_count_o
);

  // Packed so that stage k lands at bits [k*W +: W] of the flat outputs.
  logic [NUM_STAGES-1:0][SIG_W-1:0] ctrl_q, ctrl_d;
  logic [NUM_STAGES-1:0][REG_W-1:0] dest_q, dest_d;
  logic [NUM_STAGES-1:0]            valid_q, valid_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             flush_pend_q, flush_pend_d;

  logic rs_match, rt_match, kill;

  always_comb begin
    rs_match       = id_uses_rs_i && (id_rs_i == dest_q[0]);
    rt_match       = id_uses_rt_i && (id_rt_i == dest_q[0]);
    hazard_stall_o = valid_q[0] && ctrl_q[0][LOAD_BIT] && (dest_q[0] != '0) &&
                     (rs_match || rt_match);
    kill           = hazard_stall_o || flush_i || flush_pend_q;
    cmux_o         = ~kill;
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    dest_d       = dest_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    if (ext_stall_i) begin
      // A flush seen while frozen must still kill the ID instruction on release.
      if (flush_i) flush_pend_d = 1'b1;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        ctrl_d[k]  = ctrl_q[k-1];
        dest_d[k]  = dest_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      if (cmux_o) begin
        ctrl_d[0]  = id_ctrl_i;
        dest_d[0]  = id_dest_i;
        valid_d[0] = id_valid_i;
      end else begin
        ctrl_d[0]  = '0;
        dest_d[0]  = '0;
        valid_d[0] = 1'b0;
      end
      flush_pend_d = 1'b0;
      if (kill && id_valid_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q       <= '0;
      dest_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      dest_q       <= dest_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign stage_ctrl_o   = ctrl_q;
  assign stage_dest_o   = dest_q;
  assign stage_valid_o  = valid_q;
  assign bubble_count_o = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: propagation, load-use, r0 exemption, pending flush,
// reset mid-operation and counter saturation (counter built 2 bits wide).
module tb_ctrl_pipe_hazard;
  localparam int unsigned SIG_W = 24;
  localparam int unsigned NS    = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [SIG_W-1:0] id_ctrl;
  logic             id_valid;
  logic [REG_W-1:0] id_dest, id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt, ext_stall, flush;
  logic             cmux, hazard_stall;
  logic [NS*SIG_W-1:0] stage_ctrl;
  logic [NS*REG_W-1:0] stage_dest;
  logic [NS-1:0]       stage_valid;
  logic [CNT_W-1:0]    bubble_count;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_hazard #(
    .SIG_W(SIG_W), .NUM_STAGES(NS), .REG_W(REG_W), .LOAD_BIT(0), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .id_ctrl_i(id_ctrl), .id_valid_i(id_valid),
    .id_dest_i(id_dest), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
    .ext_stall_i(ext_stall), .flush_i(flush), .cmux_o(cmux),
    .hazard_stall_o(hazard_stall), .stage_ctrl_o(stage_ctrl), .stage_dest_o(stage_dest),
    .stage_valid_o(stage_valid), .bubble_count_o(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIG_W-1:0] sc(input int k);
    return stage_ctrl[k*SIG_W +: SIG_W];
  endfunction

  function automatic logic [REG_W-1:0] sd(input int k);
    return stage_dest[k*REG_W +: REG_W];
  endfunction

  task automatic set_id(input logic [SIG_W-1:0] c, input logic v, input logic [REG_W-1:0] d);
    id_ctrl  = c;
    id_valid = v;
    id_dest  = d;
  endtask

  initial begin
    rst = 1'b1; id_ctrl = '0; id_valid = 1'b0; id_dest = '0; id_rs = '0; id_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    #2;
    chk("rst_ctrl", 64'(stage_ctrl), 64'h0);
    chk("rst_dest", 64'(stage_dest), 64'h0);
    chk("rst_valid", 64'(stage_valid), 64'h0);
    chk("rst_count", 64'(bubble_count), 64'h0);
    chk("rst_cmux", 64'(cmux), 64'h1);
    chk("rst_hazard", 64'(hazard_stall), 64'h0);
    #10 rst = 1'b0;

    // Propagation
    set_id(24'hA5A5A5, 1'b1, 5'd3);
    step();
    chk("prop_s0_ctrl", 64'(sc(0)), 64'hA5A5A5);
    chk("prop_s0_valid", 64'(stage_valid[0]), 64'h1);
    set_id(24'h0, 1'b0, 5'd0);
    step();
    chk("prop_s1_ctrl", 64'(sc(1)), 64'hA5A5A5);
    chk("prop_s0_bubble", 64'(stage_valid[0]), 64'h0);
    step();
    chk("prop_s2_ctrl", 64'(sc(2)), 64'hA5A5A5);
    chk("prop_s2_dest", 64'(sd(2)), 64'h3);
    chk("prop_s2_valid", 64'(stage_valid[2]), 64'h1);
    chk("prop_count", 64'(bubble_count), 64'h0);

    // Load-use hazard on rs
    set_id(24'h000101, 1'b1, 5'd5);
    step();
    set_id(24'h000200, 1'b1, 5'd6);
    id_rs = 5'd5; id_uses_rs = 1'b1;
    #1;
    chk("lu_hazard", 64'(hazard_stall), 64'h1);
    chk("lu_cmux", 64'(cmux), 64'h0);
    step();
    chk("lu_s0_ctrl", 64'(sc(0)), 64'h0);
    chk("lu_s0_valid", 64'(stage_valid[0]), 64'h0);
    chk("lu_count", 64'(bubble_count), 64'h1);
    chk("lu_s1_ctrl", 64'(sc(1)), 64'h000101);
    chk("lu_s1_dest", 64'(sd(1)), 64'h5);
    chk("lu_hazard_gone", 64'(hazard_stall), 64'h0);
    chk("lu_cmux_back", 64'(cmux), 64'h1);
    step();
    chk("lu_s0_reissue", 64'(sc(0)), 64'h000200);
    chk("lu_count_hold", 64'(bubble_count), 64'h1);

    // r0 exemption
    id_uses_rs = 1'b0;
    set_id(24'h000001, 1'b1, 5'd0);
    step();
    set_id(24'h000400, 1'b1, 5'd7);
    id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    chk("r0_hazard", 64'(hazard_stall), 64'h0);
    chk("r0_cmux", 64'(cmux), 64'h1);
    step();
    chk("r0_s0_ctrl", 64'(sc(0)), 64'h000400);
    id_uses_rt = 1'b0;

    // Pending flush under ext_stall
    set_id(24'h000800, 1'b1, 5'd8);
    ext_stall = 1'b1;
    step();
    chk("pf_e1_s0", 64'(sc(0)), 64'h000400);
    chk("pf_e1_cmux", 64'(cmux), 64'h1);
    flush = 1'b1;
    #1;
    chk("pf_flush_cmux", 64'(cmux), 64'h0);
    step();
    flush = 1'b0;
    #1;
    chk("pf_pend_cmux", 64'(cmux), 64'h0);
    chk("pf_e2_s0", 64'(sc(0)), 64'h000400);
    chk("pf_e2_s2", 64'(sc(2)), 64'h000200);
    step();
    chk("pf_e3_cmux", 64'(cmux), 64'h0);
    chk("pf_e3_count", 64'(bubble_count), 64'h1);
    chk("pf_e3_s1", 64'(sc(1)), 64'h000001);
    ext_stall = 1'b0;
    step();
    chk("pf_rel_s0", 64'(sc(0)), 64'h0);
    chk("pf_rel_v0", 64'(stage_valid[0]), 64'h0);
    chk("pf_rel_count", 64'(bubble_count), 64'h2);
    chk("pf_rel_s1", 64'(sc(1)), 64'h000400);
    chk("pf_rel_cmux", 64'(cmux), 64'h1);

    // Reset mid-operation with full stages and flush pending
    set_id(24'h111110, 1'b1, 5'd1); step();
    set_id(24'h222220, 1'b1, 5'd2); step();
    set_id(24'h333330, 1'b1, 5'd3); step();
    chk("rm_full", 64'(stage_valid), 64'h7);
    ext_stall = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("rm_pend", 64'(cmux), 64'h0);
    rst = 1'b1;
    #1;
    chk("rm_ctrl", 64'(stage_ctrl), 64'h0);
    chk("rm_dest", 64'(stage_dest), 64'h0);
    chk("rm_valid", 64'(stage_valid), 64'h0);
    chk("rm_count", 64'(bubble_count), 64'h0);
    chk("rm_cmux", 64'(cmux), 64'h1);
    #2 rst = 1'b0;
    ext_stall = 1'b0;
    set_id(24'h444440, 1'b1, 5'd4);
    step();
    chk("rm_load_ctrl", 64'(sc(0)), 64'h444440);
    chk("rm_load_valid", 64'(stage_valid[0]), 64'h1);
    chk("rm_load_count", 64'(bubble_count), 64'h0);

    // Flushed invalid ID is a bubble but is not counted
    set_id(24'h0, 1'b0, 5'd0);
    flush = 1'b1;
    step();
    chk("inv_count", 64'(bubble_count), 64'h0);

    // Saturation of the 2-bit counter
    set_id(24'h555550, 1'b1, 5'd9);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("sat_%0d", i), 64'(bubble_count), 64'((i > 3) ? 3 : i));
    end
    flush = 1'b0;
    step();
    chk("sat_hold", 64'(bubble_count), 64'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
